ifu: RTL and testbench

Instruction fetch unit for the LemonPC core. It owns the fetch PC, issues one 32-bit instruction read at a time to the instruction memory port, and buffers returned instructions with their PCs in a small FIFO. The FIFO feeds the decode/execute stage through a valid/ready handshake. A redirect input (branch, jump or trap target) flushes buffered and in-flight fetches and restarts fetch at the new PC.

---
 rtl/ifu.sv | 163 ++++++++++++++++
 tb/tb_ifu.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// LemonPC instruction fetch unit: one outstanding imem read feeding a DEPTH-entry {pc, inst} FIFO.
// Define IFU_PERF_EN to build the perf_fetched/perf_flushed counters; otherwise both read 0.
`timescale 1ns/1ps
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
);
  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_e              state_q, state_d;
  logic [63:0]         fetch_pc_q, fetch_pc_d;
  logic [63:0]         inflight_pc_q, inflight_pc_d;
  entry_t [DEPTH-1:0]  fifo_q, fifo_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]         cnt_q, cnt_d;

  logic        req_hs, push, pop, resp_drop;
  logic [63:0] redir_pc;
  logic        unused_redir_lsb;

  assign redir_pc         = {redirect_pc[63:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];

  // Only request when a slot is free, so a returning response can always be pushed.
  assign imem_req_valid = (state_q == REQ) && (cnt_q < CNT_FULL);
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign out_valid = (cnt_q != '0) && !redirect_valid;
  assign out_pc    = fifo_q[rd_ptr_q].pc;
  assign out_inst  = fifo_q[rd_ptr_q].inst;
  assign pop       = out_valid && out_ready;

  assign push      = (state_q == WAIT) && imem_resp_valid && !redirect_valid;
  assign resp_drop = imem_resp_valid &&
                     ((state_q == DRAIN) || ((state_q == WAIT) && redirect_valid));

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (req_hs) begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + 64'd4;
          state_d       = WAIT;
        end
      end
      WAIT:  if (imem_resp_valid) state_d = REQ;
      DRAIN: if (imem_resp_valid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      case (state_q)
        REQ:   state_d = req_hs ? DRAIN : REQ;
        WAIT:  state_d = imem_resp_valid ? REQ : DRAIN;
        // A response arriving here retires the only outstanding read; nothing more to wait for.
        DRAIN: state_d = imem_resp_valid ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q].pc   = inflight_pc_q;
        fifo_d[wr_ptr_q].inst = imem_resp_data;
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      fifo_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      fifo_q        <= fifo_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, pop};
    perf_flushed_d = perf_flushed_q + {31'd0, resp_drop};
    if (redirect_valid) perf_flushed_d = perf_flushed_d + {{(31-PW){1'b0}}, cnt_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`else
  logic unused_resp_drop;
  assign unused_resp_drop = resp_drop;
  assign perf_fetched     = '0;
  assign perf_flushed     = '0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset, streaming fetch, backpressure, redirects, request stall, PC wrap, mid-run reset.
`timescale 1ns/1ps
module tb_ifu;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
`ifdef IFU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] perf_fetched, perf_flushed;

  int n_cmp = 0;
  int n_err = 0;
  int resp_lat = 1;
  logic [63:0] hs_q[$];
  logic [95:0] pop_q[$];

  ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
  );

  always #5 clk = ~clk;

  // Memory returns addr[31:0] resp_lat cycles after the handshake; also logs handshakes and pops.
  logic        pend;
  logic [63:0] pend_addr;
  int          lat_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= '0;
      pend            <= 1'b0;
      pend_addr       <= '0;
      lat_cnt         <= 0;
    end else begin
      imem_resp_valid <= 1'b0;
      if (pend) begin
        if (lat_cnt == 0) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= pend_addr[31:0];
          pend            <= 1'b0;
        end else lat_cnt <= lat_cnt - 1;
      end
      if (imem_req_valid && imem_req_ready) begin
        hs_q.push_back(imem_req_addr);
        if (resp_lat <= 1) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= imem_req_addr[31:0];
        end else begin
          pend      <= 1'b1;
          pend_addr <= imem_req_addr;
          lat_cnt   <= resp_lat - 2;
        end
      end
      if (out_valid && out_ready) pop_q.push_back({out_pc, out_inst});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; resp_lat = 1;
    repeat (2) step();
    hs_q.delete(); pop_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %h exp 0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RPC) begin n_err++; $display("FAIL rst_req_addr: got %h exp %h", imem_req_addr, RPC); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %h exp 0", out_valid); end
    n_cmp++; if (out_pc !== 64'd0) begin n_err++; $display("FAIL rst_out_pc: got %h exp 0", out_pc); end
    n_cmp++; if (out_inst !== 32'd0) begin n_err++; $display("FAIL rst_out_inst: got %h exp 0", out_inst); end
    n_cmp++; if (perf_fetched !== 32'd0) begin n_err++; $display("FAIL rst_perf_fetched: got %h exp 0", perf_fetched); end
    n_cmp++; if (perf_flushed !== 32'd0) begin n_err++; $display("FAIL rst_perf_flushed: got %h exp 0", perf_flushed); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL idle_req_valid: got %h exp 0", imem_req_valid); end
    step();
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL first_req_valid: got %h exp 1", imem_req_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    step(); // cycle 1
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL st_c1_req_valid: got %h exp 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RPC) begin n_err++; $display("FAIL st_c1_addr: got %h exp %h", imem_req_addr, RPC); end
    step(); // cycle 2: response on the bus
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL st_c2_out_valid: got %h exp 0", out_valid); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL st_c2_req_valid: got %h exp 0", imem_req_valid); end
    step(); // cycle 3: instruction visible
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL st_c3_out_valid: got %h exp 1", out_valid); end
    n_cmp++; if (out_pc !== RPC) begin n_err++; $display("FAIL st_c3_out_pc: got %h exp %h", out_pc, RPC); end
    n_cmp++; if (out_inst !== 32'h8000_0000) begin n_err++; $display("FAIL st_c3_out_inst: got %h exp 80000000", out_inst); end
    n_cmp++; if (imem_req_addr !== RPC + 64'd4) begin n_err++; $display("FAIL st_c3_addr: got %h exp %h", imem_req_addr, RPC + 64'd4); end
    repeat (5) step(); // cycle 8
    n_cmp++; if (hs_q.size() !== 4) begin n_err++; $display("FAIL st_hs_count: got %0d exp 4", hs_q.size()); end
    n_cmp++; if (hs_q[1] !== RPC + 64'd4) begin n_err++; $display("FAIL st_hs1: got %h exp %h", hs_q[1], RPC + 64'd4); end
    n_cmp++; if (hs_q[2] !== RPC + 64'd8) begin n_err++; $display("FAIL st_hs2: got %h exp %h", hs_q[2], RPC + 64'd8); end
    n_cmp++; if (pop_q.size() !== 3) begin n_err++; $display("FAIL st_pop_count: got %0d exp 3", pop_q.size()); end
    n_cmp++; if (pop_q[0] !== {RPC, 32'h8000_0000}) begin n_err++; $display("FAIL st_pop0: got %h exp %h", pop_q[0], {RPC, 32'h8000_0000}); end
    n_cmp++; if (pop_q[1] !== {RPC + 64'd4, 32'h8000_0004}) begin n_err++; $display("FAIL st_pop1: got %h exp %h", pop_q[1], {RPC + 64'd4, 32'h8000_0004}); end
    n_cmp++; if (perf_fetched !== (PERF ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL st_perf_fetched: got %0d exp %0d", perf_fetched, PERF ? 3 : 0); end
    n_cmp++; if (perf_flushed !== 32'd0) begin n_err++; $display("FAIL st_perf_flushed: got %0d exp 0", perf_flushed); end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (10) step(); // cycle 10, FIFO full
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_req_valid: got %h exp 0", imem_req_valid); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %h exp 1", out_valid); end
    n_cmp++; if (out_pc !== RPC) begin n_err++; $display("FAIL bp_out_pc: got %h exp %h", out_pc, RPC); end
    n_cmp++; if (hs_q.size() !== 2) begin n_err++; $display("FAIL bp_hs_count: got %0d exp 2", hs_q.size()); end
    out_ready = 1'b1;
    repeat (6) step(); // cycle 16
    n_cmp++; if (pop_q.size() !== 4) begin n_err++; $display("FAIL bp_pop_count: got %0d exp 4", pop_q.size()); end
    n_cmp++; if (pop_q[0] !== {RPC, 32'h8000_0000}) begin n_err++; $display("FAIL bp_pop0: got %h exp %h", pop_q[0], {RPC, 32'h8000_0000}); end
    n_cmp++; if (pop_q[1] !== {RPC + 64'd4, 32'h8000_0004}) begin n_err++; $display("FAIL bp_pop1: got %h exp %h", pop_q[1], {RPC + 64'd4, 32'h8000_0004}); end
    n_cmp++; if (perf_fetched !== (PERF ? 32'd4 : 32'd0)) begin n_err++; $display("FAIL bp_perf_fetched: got %0d exp %0d", perf_fetched, PERF ? 4 : 0); end
  endtask

  task automatic test_redirect_wait();
    int k;
    do_reset();
    resp_lat = 4;
    repeat (2) step(); // cycle 2, WAIT with a read in flight
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_1003;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rw_out_valid: got %h exp 0", out_valid); end
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rw_drain_req_valid: got %h exp 0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 64'h8000_1000) begin n_err++; $display("FAIL rw_drain_addr: got %h exp 80001000", imem_req_addr); end
    k = 0;
    while (!imem_req_valid && k < 20) begin step(); k++; end
    n_cmp++; if (k !== 3) begin n_err++; $display("FAIL rw_req_delay: got %0d exp 3 cycles", k); end
    n_cmp++; if (imem_req_addr !== 64'h8000_1000) begin n_err++; $display("FAIL rw_req_addr: got %h exp 80001000", imem_req_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rw_dropped: got out_valid %h exp 0", out_valid); end
    n_cmp++; if (perf_flushed !== (PERF ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL rw_perf_flushed: got %0d exp %0d", perf_flushed, PERF ? 1 : 0); end
    resp_lat = 1; out_ready = 1'b1;
    repeat (4) step();
    n_cmp++; if (hs_q[1] !== 64'h8000_1000) begin n_err++; $display("FAIL rw_hs1: got %h exp 80001000", hs_q[1]); end
    n_cmp++; if (pop_q[0] !== {64'h8000_1000, 32'h8000_1000}) begin n_err++; $display("FAIL rw_pop0: got %h exp %h", pop_q[0], {64'h8000_1000, 32'h8000_1000}); end
  endtask

  task automatic test_redirect_resp();
    do_reset();
    repeat (4) step(); // cycle 4: 1 entry buffered, response on the bus
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_pre_out_valid: got %h exp 1", out_valid); end
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_9000_0000;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_out_valid: got %h exp 0", out_valid); end
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_empty: got out_valid %h exp 0", out_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rr_req_valid: got %h exp 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 64'h9000_0000) begin n_err++; $display("FAIL rr_req_addr: got %h exp 90000000", imem_req_addr); end
    n_cmp++; if (perf_flushed !== (PERF ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL rr_perf_flushed: got %0d exp %0d", perf_flushed, PERF ? 2 : 0); end
    repeat (2) step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_new_valid: got %h exp 1", out_valid); end
    n_cmp++; if (out_pc !== 64'h9000_0000) begin n_err++; $display("FAIL rr_new_pc: got %h exp 90000000", out_pc); end
    n_cmp++; if (out_inst !== 32'h9000_0000) begin n_err++; $display("FAIL rr_new_inst: got %h exp 90000000", out_inst); end
  endtask

  task automatic test_req_stall();
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid_c%0d: got %h exp 1", i + 1, imem_req_valid); end
      n_cmp++; if (imem_req_addr !== RPC) begin n_err++; $display("FAIL stall_addr_c%0d: got %h exp %h", i + 1, imem_req_addr, RPC); end
    end
    imem_req_ready = 1'b1;
    step();
    n_cmp++; if (hs_q.size() !== 1) begin n_err++; $display("FAIL stall_hs_count: got %0d exp 1", hs_q.size()); end
    n_cmp++; if (hs_q[0] !== RPC) begin n_err++; $display("FAIL stall_hs0: got %h exp %h", hs_q[0], RPC); end
    n_cmp++; if (imem_req_addr !== RPC + 64'd4) begin n_err++; $display("FAIL stall_next_addr: got %h exp %h", imem_req_addr, RPC + 64'd4); end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_req_ready = 1'b0; out_ready = 1'b1;
    step(); // cycle 1, REQ with no handshake
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL wrap_req_valid: got %h exp 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_req_addr: got %h exp fffffffffffffffc", imem_req_addr); end
    imem_req_ready = 1'b1;
    step();
    n_cmp++; if (imem_req_addr !== 64'd0) begin n_err++; $display("FAIL wrap_next_addr: got %h exp 0", imem_req_addr); end
    step();
    n_cmp++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_out_pc: got %h exp fffffffffffffffc", out_pc); end
    n_cmp++; if (out_inst !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_out_inst: got %h exp fffffffc", out_inst); end
    n_cmp++; if (perf_flushed !== 32'd0) begin n_err++; $display("FAIL wrap_perf_flushed: got %0d exp 0", perf_flushed); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) step(); // 2 entries buffered
    out_ready = 1'b1;
    step(); // one popped, next read issues
    out_ready = 1'b0; resp_lat = 10;
    step(); // WAIT with an entry buffered
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre_out_valid: got %h exp 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rm_req_valid: got %h exp 0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RPC) begin n_err++; $display("FAIL rm_req_addr: got %h exp %h", imem_req_addr, RPC); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_out_valid: got %h exp 0", out_valid); end
    n_cmp++; if (out_pc !== 64'd0) begin n_err++; $display("FAIL rm_out_pc: got %h exp 0", out_pc); end
    n_cmp++; if (out_inst !== 32'd0) begin n_err++; $display("FAIL rm_out_inst: got %h exp 0", out_inst); end
    n_cmp++; if (perf_fetched !== 32'd0) begin n_err++; $display("FAIL rm_perf_fetched: got %h exp 0", perf_fetched); end
    hs_q.delete(); pop_q.delete(); resp_lat = 1;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    n_cmp++; if (hs_q.size() !== 1) begin n_err++; $display("FAIL rm_hs_count: got %0d exp 1", hs_q.size()); end
    n_cmp++; if (hs_q[0] !== RPC) begin n_err++; $display("FAIL rm_hs0: got %h exp %h", hs_q[0], RPC); end
    step();
    n_cmp++; if (out_pc !== RPC) begin n_err++; $display("FAIL rm_out_pc_after: got %h exp %h", out_pc, RPC); end
  endtask

  initial begin
    imem_req_ready = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp();
    test_req_stall();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1, "timeout");
  end
endmodule
